seq_detect_scheduler: RTL and testbench
=======================================

// Module: seq_detect_scheduler
// PURPOSE
//   Round-robin scheduler sharing one serial Moore 1101 sequence detector among NUM_REQ
//   requesters. Grants the detector to one requester per frame and clears it before the
//   frame. Streams FRAME_LEN serial bits from the granted requester into the detector,
//   counts overlapping 1101 hits, and reports the count with the winner's index.
//   Sits between requester serial sources and the detector (i -> det_i, o -> det_o).
// PARAMETERS
//   NUM_REQ    4  number of requesters (>=2)
//   FRAME_LEN  8  bits streamed per granted frame (>=4)
//   CNT_W      4  width of match counter; saturates at 2**CNT_W-1
// PORTS
//   clk         in   1                   system clock, all state on rising edge
//   rst         in   1                   synchronous, active-high reset
//   req         in   NUM_REQ             per-requester frame request, level
//   req_data    in   NUM_REQ             per-requester serial bit
//   grant       out  NUM_REQ             one-hot owner of detector; 0 when idle
//   shift_en    out  1                   granted requester's bit consumed at this edge; advance
//   det_clr     out  1                   detector clear, high one cycle before frame
//   det_i       out  1                   serial bit to detector = req_data[owner] when shift_en, else 0
//   det_o       in   1                   detector Moore output (registered in detector)
//   busy        out  1                   high in any state other than IDLE
//   done        out  1                   one-cycle pulse, result valid
//   done_id     out  $clog2(NUM_REQ)     index of requester just served
//   match_cnt   out  CNT_W               1101 hits in last frame, held until next done
// BEHAVIOUR
//   Reset (rst=1 at edge): state=IDLE, grant=0, shift_en=0, det_clr=0, busy=0, done=0,
//     done_id=0, match_cnt=0, rr pointer=0, bit counter=0. Applies from any state; a frame
//     in progress is abandoned with no done.
//   FSM: IDLE -> CLEAR -> SHIFT (FRAME_LEN cycles) -> DRAIN -> DONE -> IDLE.
//   IDLE: req sampled only here. If req!=0, winner = first set bit scanning from rr
//     pointer upward with wrap. Load grant one-hot, go to CLEAR. req=0: stay.
//   CLEAR: det_clr=1, grant held, internal hit count zeroed.
//   SHIFT: shift_en=1, det_i=req_data[owner]; bit counter 0..FRAME_LEN-1. Leave after count
//     FRAME_LEN-1.
//   DRAIN: one cycle, shift_en=0; samples det_o for the last bit (Moore latency 1).
//   Counting: in SHIFT and DRAIN, det_o=1 increments hit count by 1, saturating.
//     First SHIFT cycle sees det_o=0 (cleared detector).
//   DONE: done=1, grant=0. match_cnt/done_id updated at entry and held afterwards.
//     rr pointer = (winner+1) mod NUM_REQ. Next cycle IDLE.
//   Latency: req seen in IDLE cycle 0 -> CLEAR cycle 1 -> SHIFT cycles 2..FRAME_LEN+1 ->
//     DRAIN FRAME_LEN+2 -> done at cycle FRAME_LEN+3. Min spacing between frames FRAME_LEN+4.
//   Requester deasserting req mid-frame: ignored; frame completes and is reported.
//   New req arriving mid-frame: waits for IDLE. A requester holding req is re-served only
//     after the others (rr fairness).
//   grant is one-hot or zero at all times. det_clr and shift_en are never both high.
// CONFIGURATION
//   SEQ_SCHED_FIRST_HIT_EN defined: adds output first_hit [$clog2(FRAME_LEN+1)-1:0].
//     Value = index of the bit completing the first 1101 in the frame.
//       Hit seen in SHIFT with counter k -> k-1; hit seen in DRAIN -> FRAME_LEN-1.
//       No hit -> FRAME_LEN.
//     Updated with done, reset value FRAME_LEN.
//   Undefined: port and logic absent; all other behaviour identical.
// TESTING (NUM_REQ=4, FRAME_LEN=8, CNT_W=4; bit 0 sent first)
//   1 Hold rst=1 two cycles, mid-SHIFT and from IDLE -> next cycle grant=0, busy=0,
//     done=0, match_cnt=0. Following req=0001 served by idx 0.
//   2 req=0001, bits 1,1,0,1,1,0,1,0 -> det_clr at cycle 1, shift_en cycles 2-9, done at 11,
//     done_id=0, match_cnt=2 (overlap). first_hit=3 when enabled.
//   3 req=0100, bits all 1 then all 0 frames -> match_cnt=0 both, done_id=2.
//     first_hit=8 when enabled.
//   4 req=1111 held continuously -> done_id sequence 0,1,2,3,0. done pulses 12 cycles apart.
//     grant always one-hot.
//   5 Serve idx1, then req=0110 -> idx2 granted (pointer=2). req[2] dropped mid-SHIFT ->
//     frame still completes, done_id=2.
//   6 CNT_W=2, FRAME_LEN=16, frame 1101 repeated with overlap (1,1,0,1,1,0,1,1,0,1,...)
//     -> match_cnt saturates at 3.

Source files
------------

// File: rtl/seq_detect_scheduler.sv
// Round-robin scheduler sharing one serial Moore 1101 detector among NUM_REQ requesters.
// Optional first-hit index output enabled by defining SEQ_SCHED_FIRST_HIT_EN.
module seq_detect_scheduler #(
    parameter int NUM_REQ   = 4,
    parameter int FRAME_LEN = 8,
    parameter int CNT_W     = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ-1:0]         req_data,
    output logic [NUM_REQ-1:0]         grant,
    output logic                       shift_en,
    output logic                       det_clr,
    output logic                       det_i,
    input  logic                       det_o,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(NUM_REQ)-1:0] done_id,
    output logic [CNT_W-1:0]           match_cnt
`ifdef SEQ_SCHED_FIRST_HIT_EN
    ,
    output logic [$clog2(FRAME_LEN+1)-1:0] first_hit
`endif
);

    localparam int ID_W = $clog2(NUM_REQ);
    localparam int BC_W = $clog2(FRAME_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_SHIFT,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             state_q;
    logic [NUM_REQ-1:0] grant_q;
    logic               shift_en_q;
    logic               det_clr_q;
    logic               busy_q;
    logic               done_q;
    logic [ID_W-1:0]    done_id_q;
    logic [CNT_W-1:0]   match_cnt_q;
    logic [ID_W-1:0]    rr_q;
    logic [ID_W-1:0]    owner_q;
    logic [BC_W-1:0]    bit_cnt_q;
    logic [CNT_W-1:0]   hit_q;

    logic [CNT_W-1:0]   hit_d;
    logic               win_vld_d;
    logic [ID_W-1:0]    win_idx_d;
    logic [ID_W-1:0]    cand_idx;

`ifdef SEQ_SCHED_FIRST_HIT_EN
    localparam int FH_W = $clog2(FRAME_LEN+1);
    logic [FH_W-1:0] fh_q;
    logic [FH_W-1:0] first_hit_q;
    logic            fh_new;
    assign fh_new    = det_o && (fh_q == FH_W'(FRAME_LEN));
    assign first_hit = first_hit_q;
`endif

    // First requesting index at or above the rr pointer, wrapping.
    always_comb begin
        win_vld_d = 1'b0;
        win_idx_d = '0;
        cand_idx  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand_idx = ID_W'((32'(rr_q) + i) % NUM_REQ);
            if (!win_vld_d && req[cand_idx]) begin
                win_vld_d = 1'b1;
                win_idx_d = cand_idx;
            end
        end
    end

    assign hit_d = (det_o && (hit_q != CNT_MAX)) ? hit_q + 1'b1 : hit_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            grant_q     <= '0;
            shift_en_q  <= 1'b0;
            det_clr_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            done_id_q   <= '0;
            match_cnt_q <= '0;
            rr_q        <= '0;
            owner_q     <= '0;
            bit_cnt_q   <= '0;
            hit_q       <= '0;
`ifdef SEQ_SCHED_FIRST_HIT_EN
            fh_q        <= FH_W'(FRAME_LEN);
            first_hit_q <= FH_W'(FRAME_LEN);
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (win_vld_d) begin
                        owner_q   <= win_idx_d;
                        grant_q   <= NUM_REQ'(1) << win_idx_d;
                        det_clr_q <= 1'b1;
                        busy_q    <= 1'b1;
                        hit_q     <= '0;
                        state_q   <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    det_clr_q  <= 1'b0;
                    shift_en_q <= 1'b1;
                    bit_cnt_q  <= '0;
`ifdef SEQ_SCHED_FIRST_HIT_EN
                    fh_q       <= FH_W'(FRAME_LEN);
`endif
                    state_q    <= S_SHIFT;
                end
                S_SHIFT: begin
                    hit_q <= hit_d;
`ifdef SEQ_SCHED_FIRST_HIT_EN
                    // det_o lags the shifted bit by one cycle
                    if (fh_new) fh_q <= FH_W'(bit_cnt_q) - FH_W'(1);
`endif
                    if (bit_cnt_q == BC_W'(FRAME_LEN-1)) begin
                        shift_en_q <= 1'b0;
                        state_q    <= S_DRAIN;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                    end
                end
                S_DRAIN: begin
                    match_cnt_q <= hit_d;
                    done_id_q   <= owner_q;
`ifdef SEQ_SCHED_FIRST_HIT_EN
                    first_hit_q <= fh_new ? FH_W'(FRAME_LEN-1) : fh_q;
`endif
                    done_q      <= 1'b1;
                    grant_q     <= '0;
                    rr_q        <= ID_W'((32'(owner_q) + 1) % NUM_REQ);
                    state_q     <= S_DONE;
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign grant     = grant_q;
    assign shift_en  = shift_en_q;
    assign det_clr   = det_clr_q;
    assign det_i     = shift_en_q & req_data[owner_q];
    assign busy      = busy_q;
    assign done      = done_q;
    assign done_id   = done_id_q;
    assign match_cnt = match_cnt_q;

endmodule

// File: tb/tb_seq_detect_scheduler.sv
// Directed bench for seq_detect_scheduler with behavioural Moore 1101 detectors attached.
// Honours SEQ_SCHED_FIRST_HIT_EN for the first_hit output.
module tb_seq_detect_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req, req_data, grant;
    logic       shift_en, det_clr, det_i, det_o, busy, done;
    logic [1:0] done_id;
    logic [3:0] match_cnt;
`ifdef SEQ_SCHED_FIRST_HIT_EN
    logic [3:0] first_hit;
    logic [4:0] first_hit6;
`endif
    logic [3:0] req6, req_data6, grant6;
    logic       shift_en6, det_clr6, det_i6, det_o6, busy6, done6;
    logic [1:0] done_id6;
    logic [1:0] match_cnt6;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_done = 0;

    always #5 clk = ~clk;

    seq_detect_scheduler #(.NUM_REQ(4), .FRAME_LEN(8), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .grant(grant),
        .shift_en(shift_en), .det_clr(det_clr), .det_i(det_i), .det_o(det_o),
        .busy(busy), .done(done), .done_id(done_id), .match_cnt(match_cnt)
`ifdef SEQ_SCHED_FIRST_HIT_EN
        , .first_hit(first_hit)
`endif
    );

    seq_detect_scheduler #(.NUM_REQ(4), .FRAME_LEN(16), .CNT_W(2)) dut6 (
        .clk(clk), .rst(rst), .req(req6), .req_data(req_data6), .grant(grant6),
        .shift_en(shift_en6), .det_clr(det_clr6), .det_i(det_i6), .det_o(det_o6),
        .busy(busy6), .done(done6), .done_id(done_id6), .match_cnt(match_cnt6)
`ifdef SEQ_SCHED_FIRST_HIT_EN
        , .first_hit(first_hit6)
`endif
    );

    // Overlapping 1101 Moore detector: 0 none, 1 "1", 2 "11", 3 "110", 4 match.
    function automatic logic [2:0] det_next(input logic [2:0] s, input logic b);
        case (s)
            3'd0:    det_next = b ? 3'd1 : 3'd0;
            3'd1:    det_next = b ? 3'd2 : 3'd0;
            3'd2:    det_next = b ? 3'd2 : 3'd3;
            3'd3:    det_next = b ? 3'd4 : 3'd0;
            default: det_next = b ? 3'd2 : 3'd0;
        endcase
    endfunction

    logic [2:0] ds = 3'd0;
    logic [2:0] ds6 = 3'd0;
    always @(posedge clk) begin
        if (det_clr) ds <= 3'd0;
        else if (shift_en) ds <= det_next(ds, det_i);
        if (det_clr6) ds6 <= 3'd0;
        else if (shift_en6) ds6 <= det_next(ds6, det_i6);
    end
    assign det_o  = (ds == 3'd4);
    assign det_o6 = (ds6 == 3'd4);

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One frame on dut: returns at the IDLE cycle after done.
    task automatic frame(input logic [3:0] r, input logic [3:0] r_after, input logic [7:0] bits,
                         input int exp_id, input int exp_cnt, input int exp_fh, input string tag);
        int   t0, nsh;
        logic got, bad_proto, bad_di, b;
        logic [3:0] oh;
        oh = 4'(1 << exp_id);
        req = r;
        req_data = '0;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            tick();
            if (det_clr) got = 1'b1;
        end
        check(32'(got), 1, {tag, "_clr_seen"});
        t0 = cyc;
        check(32'(grant), 32'(oh), {tag, "_grant"});
        check(32'(busy), 1, {tag, "_busy"});
        nsh = 0;
        got = 1'b0;
        bad_proto = 1'b0;
        bad_di = 1'b0;
        for (int k = 0; k < 30 && !got; k++) begin
            tick();
            if ($countones(grant) > 1 || (det_clr && shift_en)) bad_proto = 1'b1;
            if (done) begin
                got = 1'b1;
            end else if (shift_en) begin
                b = (nsh < 8) ? bits[nsh[2:0]] : 1'b0;
                req_data = b ? oh : ~oh;
                #1;
                if (det_i !== b) bad_di = 1'b1;
                nsh++;
                if (nsh == 2) req = r_after;
            end
        end
        check(32'(got), 1, {tag, "_done_seen"});
        check(32'(cyc - t0), 10, {tag, "_done_latency"});
        check(32'(nsh), 8, {tag, "_shift_cycles"});
        check(32'(done_id), 32'(exp_id), {tag, "_done_id"});
        check(32'(match_cnt), 32'(exp_cnt), {tag, "_match_cnt"});
`ifdef SEQ_SCHED_FIRST_HIT_EN
        check(32'(first_hit), 32'(exp_fh), {tag, "_first_hit"});
`else
        if (exp_fh < 0) $display("unused first_hit expectation");
`endif
        check(32'(grant), 0, {tag, "_grant_at_done"});
        check(32'(bad_proto), 0, {tag, "_onehot_excl"});
        check(32'(bad_di), 0, {tag, "_det_i"});
        last_done = cyc;
        tick();
        check(32'(done), 0, {tag, "_done_pulse"});
        check(32'(busy), 0, {tag, "_idle"});
        check(32'(match_cnt), 32'(exp_cnt), {tag, "_cnt_held"});
    endtask

    task automatic reset_checks(input string tag);
        check(32'(grant), 0, {tag, "_grant"});
        check(32'(busy), 0, {tag, "_busy"});
        check(32'(done), 0, {tag, "_done"});
        check(32'(match_cnt), 0, {tag, "_match_cnt"});
        check(32'(done_id), 0, {tag, "_done_id"});
`ifdef SEQ_SCHED_FIRST_HIT_EN
        check(32'(first_hit), 8, {tag, "_first_hit"});
`endif
    endtask

    initial begin
        int   prev, n;
        logic got;
        rst = 1'b1;
        req = '0;
        req_data = '0;
        req6 = '0;
        req_data6 = '0;
        tick();
        tick();
        rst = 1'b0;
        reset_checks("por");

        // Overlapping hits: bits 1,1,0,1,1,0,1,0
        frame(4'b0001, 4'b0000, 8'h5B, 0, 2, 3, "ovl");

        // Reset in the middle of SHIFT abandons the frame
        req = 4'b0010;
        for (int k = 0; k < 20 && !shift_en; k++) tick();
        check(32'(shift_en), 1, "midrst_in_shift");
        tick();
        tick();
        req = '0;
        rst = 1'b1;
        tick();
        reset_checks("midrst");
        tick();
        rst = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 14; k++) begin
            tick();
            if (done || busy) got = 1'b1;
        end
        check(32'(got), 0, "midrst_abandoned");

        // rr pointer back at 0 after reset; hit completed by the last bit lands in DRAIN
        frame(4'b0011, 4'b0000, 8'hB0, 0, 1, 7, "drain_hit");
        frame(4'b0100, 4'b0000, 8'hFF, 2, 0, 8, "ones");
        frame(4'b0100, 4'b0000, 8'h00, 2, 0, 8, "zeros");

        // Reset from IDLE
        rst = 1'b1;
        tick();
        reset_checks("idlerst");
        tick();
        rst = 1'b0;

        // All requesting continuously: rotation and frame spacing
        frame(4'b1111, 4'b1111, 8'h5B, 0, 2, 3, "rr0");
        prev = last_done;
        frame(4'b1111, 4'b1111, 8'hB0, 1, 1, 7, "rr1");
        check(32'(last_done - prev), 12, "rr1_spacing");
        prev = last_done;
        frame(4'b1111, 4'b1111, 8'hFF, 2, 0, 8, "rr2");
        check(32'(last_done - prev), 12, "rr2_spacing");
        prev = last_done;
        frame(4'b1111, 4'b1111, 8'h00, 3, 0, 8, "rr3");
        check(32'(last_done - prev), 12, "rr3_spacing");
        prev = last_done;
        frame(4'b1111, 4'b1111, 8'hDB, 0, 2, 3, "rr4");
        check(32'(last_done - prev), 12, "rr4_spacing");

        // Pointer after idx1 is 2; dropping req[2] mid-frame still completes it
        frame(4'b0010, 4'b0000, 8'h5B, 1, 2, 3, "p_idx1");
        frame(4'b0110, 4'b0010, 8'hB0, 2, 1, 7, "p_drop");
        frame(4'b0010, 4'b0000, 8'hFF, 1, 0, 8, "p_after");
        req = '0;

        // Saturation on the CNT_W=2, FRAME_LEN=16 instance
        req6 = 4'b0001;
        n = 0;
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            tick();
            if (done6) begin
                got = 1'b1;
            end else if (shift_en6) begin
                req_data6 = {3'b000, ((n % 3) != 2)};
                n++;
                req6 = '0;
            end
        end
        check(32'(got), 1, "sat_done_seen");
        check(32'(n), 16, "sat_shift_cycles");
        check(32'(done_id6), 0, "sat_done_id");
        check(32'(match_cnt6), 3, "sat_match_cnt");
`ifdef SEQ_SCHED_FIRST_HIT_EN
        check(32'(first_hit6), 3, "sat_first_hit");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
